// File: rtl/odd_even_sort_unit.sv
//------------------------------------------------------------------------------
// Module      : odd_even_sort_unit
// Description : Sorts N unsigned W-bit lanes by odd-even transposition. Every
//               comparator of one parity fires in parallel each cycle, so a
//               window is ordered after at most N phases. Ascending and
//               descending modes are supported, and the median lane is
//               exported directly.
// Revision    : 1.0 - initial release
//
// Optional feature macro: SORT_EARLY_EXIT_EN
//   When defined, two consecutive phases without a swap end the sort early.
//   When undefined, exactly N phases always run.
//
// Parameters:
//   N  number of lanes (2..32)
//   W  lane width in bits (unsigned)
//
// Ports:
//   CLK         in   rising-edge clock
//   RST         in   synchronous active-high reset
//   start_i     in   level request, sampled only in IDLE
//   descend_i   in   0 = ascending, 1 = descending, captured at load
//   in_data_i   in   N*W packed input lanes, lane k = [k*W +: W]
//   out_data_o  out  N*W packed working/result lanes
//   median_o    out  lane (N-1)/2 of out_data_o
//   busy_o      out  high while sorting
//   valid_o     out  high while the result is held (DONE)
//------------------------------------------------------------------------------
`default_nettype none

module odd_even_sort_unit #(
  parameter int N = 9,
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start_i,
  input  logic           descend_i,
  input  logic [N*W-1:0] in_data_i,
  output logic [N*W-1:0] out_data_o,
  output logic [W-1:0]   median_o,
  output logic           busy_o,
  output logic           valid_o
);

  localparam int            PW      = $clog2(N + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  lanes_q [N];
  logic [W-1:0]  lanes_d [N];
  logic [PW-1:0] ph_q;
  logic          mode_q;
  logic          busy_q;
  logic          valid_q;
  logic          finish_d;

`ifdef SORT_EARLY_EXIT_EN
  logic          prev_clean_q;
  logic          swap_any;
`endif

  // One transposition phase. Pairs of the active parity are disjoint, so all
  // of them can be evaluated against the current lanes in parallel.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      lanes_d[k] = lanes_q[k];
    end
`ifdef SORT_EARLY_EXIT_EN
    swap_any = 1'b0;
`endif
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == ph_q[0]) begin
        if (mode_q ? (lanes_q[i] < lanes_q[i+1]) : (lanes_q[i] > lanes_q[i+1])) begin
          lanes_d[i]   = lanes_q[i+1];
          lanes_d[i+1] = lanes_q[i];
`ifdef SORT_EARLY_EXIT_EN
          swap_any     = 1'b1;
`endif
        end
      end
    end
  end

  // The current phase is the last one: either the fixed phase budget is used
  // up, or (early exit) this phase and the previous one were both clean.
  always_comb begin
    finish_d = (ph_q == PH_LAST);
`ifdef SORT_EARLY_EXIT_EN
    if (!swap_any && prev_clean_q) begin
      finish_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ph_q    <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        lanes_q[k] <= '0;
      end
`ifdef SORT_EARLY_EXIT_EN
      prev_clean_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            for (int k = 0; k < N; k++) begin
              lanes_q[k] <= in_data_i[k*W +: W];
            end
            mode_q  <= descend_i;
            ph_q    <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            state_q <= SORT;
`ifdef SORT_EARLY_EXIT_EN
            prev_clean_q <= 1'b0;
`endif
          end
        end
        SORT: begin
          lanes_q <= lanes_d;
          ph_q    <= ph_q + PW'(1);
`ifdef SORT_EARLY_EXIT_EN
          prev_clean_q <= !swap_any;
`endif
          if (finish_d) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // A held request must not re-sort the frozen result.
          if (!start_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign out_data_o[k*W +: W] = lanes_q[k];
  end

  assign median_o = lanes_q[(N-1)/2];
  assign busy_o   = busy_q;
  assign valid_o  = valid_q;

endmodule

`default_nettype wire

// File: doc/odd_even_sort_unit.md
# odd_even_sort_unit

Parametrised successor to the fixed nine-entry sequential sorter used by the median filter. It sorts N unsigned W-bit values with odd-even transposition: all comparators of one parity fire in parallel each cycle, so N values sort in at most N cycles. It also provides an ascending/descending mode, a direct median output and an optional early exit. It sits between the window-gathering logic and the pixel writer, under the same level start/valid handshake as its predecessor.

## Interface
- `N`, default 9: number of lanes; legal range 2..32.
- `W`, default 8: lane width in bits, unsigned.
- `CLK  in  1`: rising-edge clock; the only clock.
- `RST  in  1`: reset, synchronous and active-high.
- `start_i  in  1`: level request; sampled only in IDLE.
- `descend_i  in  1`: 0 sorts ascending, 1 sorts descending; captured at load.
- `in_data_i  in  N*W`: input lanes; lane k = `in_data_i[k*W +: W]`.
- `out_data_o  out  N*W`: working/result lanes, same packing; lane 0 is the min (ascending) or max (descending).
- `median_o  out  W`: lane (N-1)/2 of `out_data_o`; lower median when N is even.
- `busy_o  out  1`: 1 in LOAD-to-SORT phases (state SORT).
- `valid_o  out  1`: 1 in state DONE only.

## Operation
- States: IDLE, SORT, DONE (2-bit encoding).
- IDLE:
  - If start_i=1, load all lanes from in_data_i.
  - Capture descend_i into the mode register.
  - Clear the phase counter `ph` and go to SORT.
  - Otherwise hold.
- SORT, one phase per cycle:
  - Even phase (`ph[0]=0`) compares pairs (0,1),(2,3),…
  - Odd phase compares pairs (1,2),(3,4),…
  - An unpaired end lane holds its value.
- Swap rule per pair (lo, hi):
  - Ascending swaps when lane_lo > lane_hi; descending swaps when lane_lo < lane_hi.
  - Equal values never swap.
  - Comparison is unsigned, full W bits.
- `ph` width is clog2(N+1). It increments each SORT cycle.
- When `ph == N-1` at a clock edge, that edge performs the final phase and moves to DONE.
- DONE:
  - Lanes frozen and valid_o=1.
  - Return to IDLE when start_i=0.
  - start_i held at 1 keeps DONE and does not re-sort.
- start_i and descend_i changes during SORT are ignored. in_data_i is don't-care outside the IDLE load edge.
- out_data_o shows intermediate lane contents during SORT. Downstream logic uses them only when valid_o=1.

## Timing
- Reset (RST=1 at an edge):
  - state IDLE, all lanes 0, ph 0, mode ascending.
  - valid_o=0, busy_o=0, median_o=0.
  - Reset mid-SORT or in DONE aborts immediately; no partial result is flagged valid.
- RST has priority over every other input on the same edge.
- Latency, with the load edge as edge 0:
  - Phases execute on edges 1..N.
  - valid_o rises after edge N, i.e. N+1 edges from the start_i sample.
  - N=9 gives 10 edges.
- Throughput: one result per N+2 cycles minimum, including one IDLE cycle with start_i=0 between jobs.
- Outputs are registered; no combinational path from any input to any output.

## Configuration
- Macro `SORT_EARLY_EXIT_EN`, defined in common.vh or on the command line.
- Defined:
  - A `swapped` flag records whether any pair swapped in the current phase; a `prev_clean` register records that the previous phase swapped nothing.
  - If the current phase swaps nothing and prev_clean=1 (ph≥1), that edge moves to DONE.
  - Two consecutive clean phases guarantee sorted order.
  - Minimum latency is 3 edges (already-sorted input); worst case is unchanged at N+1.
  - prev_clean clears on load and on reset.
- Undefined: a fixed N phases always run; no swap-tracking logic is generated.

## Test plan
- Reversed input: N=9, W=8, lanes 9,8,…,1, ascending, start_i=1 → valid_o after 10 edges; lanes 1..9; median_o=5; busy_o high on edges 1..9.
- Descending mode with duplicates: lanes 3,7,7,0,255,1,3,200,7, descend_i=1 → lanes 255,200,7,7,7,3,3,1,0; median_o=7.
- Early exit: already-sorted 0..8 with SORT_EARLY_EXIT_EN → valid_o after edge 2; without the macro → valid_o after edge 9; identical lanes in both builds.
- Reset mid-sort: RST=1 at edge 4 of a sort → next cycle IDLE, all lanes 0, valid_o=0. A fresh start then completes normally in 10 edges.
- Handshake hold: start_i held high through DONE for 5 cycles → valid_o stays 1 and lanes are unchanged. Drop start_i → IDLE next edge. Reassert with a new window → new result.
- Parameter sweep: N=2 and N=32 with W=12 on random data versus a reference sort, 1000 windows each. Every result is ordered, median_o equals lane (N-1)/2, and latency is exactly N+1 edges.
